// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction-memory (I-cache) request bus between the fetch stage and the
// I-cache.
//   imem_req   : fetch stage -> cache, a fetch is wanted for imem_addr.
//   imem_addr  : fetch stage -> cache, address being fetched (the PC).
//   imem_ready : cache -> fetch stage, imem_data is valid for imem_addr now.
//   imem_data  : cache -> fetch stage, instruction word.
// Handshake: a word is transferred in every cycle where imem_req=1 and
// imem_ready=1. imem_ready refers only to the address presented in that same
// cycle. The address may change after any cycle, whether or not a word was
// transferred. Data returned for an address that is no longer presented is
// never qualified.
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 16-bit pipelined core. It owns the PC and
// the next-PC selection, runs the I-cache request handshake, inserts bubbles
// on a miss or a flush, detects HLT, and counts miss cycles.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : hazard-unit hold, freezes the PC and IF/ID
//   branch_taken    : taken redirect from ID; squashes the current slot
//   branch_target   : redirect address
//   imem            : I-cache bus (master side)
//   pc_out/pc_plus2 : PC of the presented slot and PC+2
//   instr_out       : instruction, or NOP_INSTR when if_valid=0
//   if_valid        : instr_out holds a real instruction
//   hlt_out         : the presented instruction is HLT
//   wen_ifid        : IF/ID write enable
//   miss_cycles     : saturating count of cycles spent in MISS
//   state_dbg       : current FSM state (FETCH=0, MISS=1, HALTED=2)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [15:0]              branch_target,
  if_fetch_stage_if.master         imem,
  output logic [15:0]              pc_out,
  output logic [15:0]              pc_plus2,
  output logic [15:0]              instr_out,
  output logic                     if_valid,
  output logic                     hlt_out,
  output logic                     wen_ifid,
  output logic [15:0]              miss_cycles,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_MISS   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic [15:0] r_miss_cycles;
  logic [15:0] w_pc_inc;
  logic        w_hit;
  logic        w_is_hlt;

  assign w_pc_inc = r_pc + 16'd2;

  // The reset term keeps the slot a bubble while rst is held, even if the
  // cache reports ready for RESET_PC.
  assign w_hit    = imem.imem_ready & ~rst & (r_state != S_HALTED);
  assign w_is_hlt = (imem.imem_data[15:12] == HLT_OPCODE);

  assign imem.imem_addr = r_pc;
  assign imem.imem_req  = (r_state != S_HALTED);

  assign pc_out      = r_pc;
  assign pc_plus2    = w_pc_inc;
  assign if_valid    = w_hit & ~branch_taken;
  assign instr_out   = if_valid ? imem.imem_data : NOP_INSTR;
  assign hlt_out     = if_valid & w_is_hlt;
  // A flush must write its bubble even while the hazard unit is holding.
  assign wen_ifid    = ~stall | branch_taken;
  assign miss_cycles = r_miss_cycles;
  assign state_dbg   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_miss_cycles <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      // Counts every MISS cycle, stalled or not.
      if ((r_state == S_MISS) && (r_miss_cycles != 16'hFFFF)) begin
        r_miss_cycles <= r_miss_cycles + 16'd1;
      end
    end
  end

  // Priority: redirect, then stall, then hit/miss.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (branch_taken) begin
      w_state_next = S_FETCH;
      w_pc_next    = branch_target;
    end else if (stall) begin
      // Any hit this cycle is dropped and re-fetched from the same PC.
      w_state_next = r_state;
    end else begin
      case (r_state)
        S_FETCH, S_MISS: begin
          if (w_hit) begin
            if (w_is_hlt) begin
              w_state_next = S_HALTED;
            end else begin
              w_state_next = S_FETCH;
              w_pc_next    = w_pc_inc;
            end
          end else begin
            w_state_next = S_MISS;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined core; drives the IF/ID pipeline register directly.
- Owns the PC register and next-PC selection (PC+2, taken-branch redirect, hold).
- Runs the I-cache request handshake, inserts bubbles on miss/flush, detects HLT, and counts miss cycles for performance reporting.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, encoding driven on instr_out when the slot is a bubble.
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) identifying HLT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit hold; freezes PC and IF/ID.
- branch_taken  in  1  resolved taken branch/jump from ID; redirect and flush.
- branch_target  in  16  redirect address, valid with branch_taken.
- imem_ready  in  1  I-cache: imem_data valid for the current imem_addr this cycle.
- imem_data  in  16  I-cache read data.
- imem_addr  out  16  fetch address, always equal to the PC register.
- imem_req  out  1  fetch request; 1 in FETCH and MISS, 0 in HALTED.
- pc_out  out  16  PC of the instruction presented on instr_out.
- pc_plus2  out  16  pc_out + 2, mod 2^16.
- instr_out  out  16  fetched instruction, or NOP_INSTR when if_valid=0.
- if_valid  out  1  instr_out holds a real instruction.
- hlt_out  out  1  presented instruction is HLT, being written this cycle.
- wen_ifid  out  1  write enable for the IF/ID register.
- miss_cycles  out  16  saturating count of cycles spent in MISS.

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-miss:
  - PC=RESET_PC, state=FETCH, miss_cycles=0.
  - Outputs during reset: imem_addr=RESET_PC, if_valid=0, hlt_out=0, instr_out=NOP_INSTR, wen_ifid=1, imem_req=1.
- States: FETCH, MISS, HALTED.
- hit = imem_ready & state!=HALTED.
- Combinational outputs:
  - if_valid = hit & ~branch_taken.
  - instr_out = if_valid ? imem_data : NOP_INSTR.
  - hlt_out = if_valid & (imem_data[15:12]==HLT_OPCODE).
  - pc_out = PC; pc_plus2 = PC+2.
  - wen_ifid = ~stall | branch_taken.
- Priority each cycle: branch_taken > stall > miss/hit.
- branch_taken=1, any state:
  - Slot is squashed: bubble written to IF/ID, even when stall=1.
  - PC <= branch_target; state <= FETCH. Exits HALTED and overrides a same-cycle HLT.
- stall=1, no branch:
  - PC and state hold; wen_ifid=0.
  - A hit this cycle is discarded and re-fetched next cycle.
- No stall, no branch, state FETCH or MISS:
  - hit & HLT: PC holds, state <= HALTED.
  - hit & not HLT: PC <= PC+2, state <= FETCH.
  - ~imem_ready: PC holds, state <= MISS, bubble written.
- HALTED:
  - imem_req=0, if_valid=0, bubbles written, PC frozen.
  - Left only via rst or branch_taken.
- miss_cycles increments on every clock edge with state==MISS, saturating at 16'hFFFF. It counts regardless of stall and is cleared only by rst.
- PC increments wrap 16'hFFFE -> 16'h0000.
- imem_addr tracks PC after a redirect, so any fill returned for the old address is never qualified. The I-cache must assert imem_ready only for the current address.
- Single-cycle hit latency: the instruction appears in IF/ID the edge after its address is presented.

Test Plan:
- Reset, imem_ready=1, sequential non-HLT data -> PC 0000,0002,0004 on consecutive cycles; if_valid=1; wen_ifid=1; pc_plus2 = PC+2.
- imem_ready=0 for 3 cycles at PC=0x0010 -> PC held at 0x0010, three bubbles (instr_out=0000, if_valid=0), state MISS, miss_cycles=3; on ready, instr valid and PC=0x0012.
- stall=1 for 2 cycles at PC=0x0020 with hit -> wen_ifid=0, PC stays 0x0020; after release, same instruction is delivered and PC=0x0022.
- branch_taken with target 0x0100 during MISS, with stall=1 -> bubble written (wen_ifid=1, if_valid=0), next PC=0x0100, state FETCH.
- Fetch 16'hF000 at 0x0030 -> hlt_out=1 for one cycle, then HALTED with imem_req=0 and PC frozen at 0x0030; later branch_taken to 0x0040 resumes fetching at 0x0040.
- Same-cycle HLT hit and branch_taken to 0x0050 -> hlt_out=0, no halt, PC=0x0050. Separately, assert rst mid-MISS -> PC=0000, miss_cycles=0, state FETCH immediately.
